// File: rtl/systolic_load_ctrl.sv
// Load/compute sequencer for the systolic MAC input path.
// Optional load-stall watchdog is built in when LOAD_TIMEOUT_EN is defined.
module systolic_load_ctrl #(
  parameter int unsigned N              = 4,
  parameter int unsigned COMPUTE_CYCLES = 3 * N - 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     src_valid,
  output logic                     dest_ready,
  output logic                     next_row,
  output logic                     next_col,
  output logic                     acc_clear,
  output logic                     shift_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(N+1)-1:0]   beat_cnt
);

  localparam int unsigned BW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            dest_ready_q, dest_ready_d;
  logic            next_q, next_d;
  logic            acc_clear_q, acc_clear_d;
  logic            shift_en_q, shift_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept_c;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_c;
`else
  // The timeout limit only matters when the watchdog is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign accept_c = dest_ready_q & src_valid;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
`ifdef LOAD_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_c = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
`ifdef LOAD_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_LOAD: begin
        if (beat_q == BW'(N)) begin
          state_d = S_COMPUTE;
          cyc_d   = '0;
        end else if (accept_c) begin
          beat_d = beat_q + BW'(1);
`ifdef LOAD_TIMEOUT_EN
          wd_d   = '0;
`endif
        end else begin
`ifdef LOAD_TIMEOUT_EN
          if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            timeout_c = 1'b1;
            state_d   = S_IDLE;
            beat_d    = '0;
            wd_d      = '0;
          end else begin
            wd_d = wd_q + WW'(1);
          end
`endif
        end
      end
      S_COMPUTE: begin
        if (cyc_q == CW'(COMPUTE_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start or timeout.
    if (abort) begin
      state_d = S_IDLE;
      beat_d  = '0;
      cyc_d   = '0;
`ifdef LOAD_TIMEOUT_EN
      wd_d      = '0;
      timeout_c = 1'b0;
`endif
    end

    busy_d       = (state_d != S_IDLE);
    dest_ready_d = (state_d == S_LOAD) && (beat_d < BW'(N));
    acc_clear_d  = (state_q == S_IDLE) && (state_d == S_LOAD);
    next_d       = accept_c && !abort;
    shift_en_d   = (state_d == S_COMPUTE);
    done_d       = (state_d == S_DONE);
`ifdef LOAD_TIMEOUT_EN
    err_d        = timeout_c;
`else
    err_d        = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      cyc_q        <= '0;
      dest_ready_q <= 1'b0;
      next_q       <= 1'b0;
      acc_clear_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cyc_q        <= cyc_d;
      dest_ready_q <= dest_ready_d;
      next_q       <= next_d;
      acc_clear_q  <= acc_clear_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOAD_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign dest_ready = dest_ready_q;
  assign next_row   = next_q;
  assign next_col   = next_q;
  assign acc_clear  = acc_clear_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign beat_cnt   = beat_q;

endmodule

// File: tb/tb_systolic_load_ctrl.sv
// Self-checking bench for systolic_load_ctrl: per-cycle job schedule model vs DUT.
module tb_systolic_load_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned C    = 10;
  localparam int unsigned TO   = 64;
  localparam int unsigned BW   = $clog2(N + 1);
  localparam int          MAXK = 128;

  logic          clk = 1'b0;
  logic          reset, start, abort, src_valid;
  logic          dest_ready, next_row, next_col, acc_clear, shift_en, busy, done, err;
  logic [BW-1:0] beat_cnt;

  always #5 clk = ~clk;

  systolic_load_ctrl #(.N(N), .COMPUTE_CYCLES(C), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .src_valid(src_valid),
    .dest_ready(dest_ready), .next_row(next_row), .next_col(next_col),
    .acc_clear(acc_clear), .shift_en(shift_en), .busy(busy), .done(done),
    .err(err), .beat_cnt(beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Output vector bits: 7 busy, 6 dest_ready, 5 next_row, 4 next_col,
  // 3 acc_clear, 2 shift_en, 1 done, 0 err
  logic          st_start[MAXK];
  logic          st_abort[MAXK];
  logic          st_valid[MAXK];
  logic [7:0]    exp_o[MAXK];
  logic [7:0]    obs_o[MAXK];
  logic [BW-1:0] exp_bc[MAXK];
  logic [BW-1:0] obs_bc[MAXK];
  logic          exp_bc_en[MAXK];

  task automatic clear_stim();
    for (int i = 0; i < MAXK; i++) begin
      st_start[i] = 1'b0;
      st_abort[i] = 1'b0;
      st_valid[i] = 1'b0;
    end
  endtask

  // Expected per-cycle outputs derived from the job timeline: each job is a
  // load phase of N accepted beats, one hand-off cycle, C compute cycles and
  // a done cycle; an abort cuts the job off after the cycle it is seen in.
  task automatic build_model(input int k);
    int c, cc, beats;
    bit stop;
    for (int i = 0; i < MAXK; i++) begin
      exp_o[i]     = '0;
      exp_bc[i]    = '0;
      exp_bc_en[i] = 1'b0;
    end
    c = 0;
    while (c < k) begin
      if (st_start[c] && !st_abort[c]) begin
        cc    = c + 1;
        beats = 0;
        stop  = 1'b0;
        if (cc < k) exp_o[cc][3] = 1'b1;
        while (!stop && beats < int'(N) && cc < k) begin
          exp_o[cc][7] = 1'b1;
          exp_o[cc][6] = 1'b1;
          exp_bc_en[cc] = 1'b1;
          exp_bc[cc]    = BW'(beats);
          if (st_abort[cc]) stop = 1'b1;
          else if (st_valid[cc]) begin
            beats++;
            exp_o[cc+1][5] = 1'b1;
            exp_o[cc+1][4] = 1'b1;
          end
          cc++;
        end
        if (!stop && cc < k) begin
          exp_o[cc][7]  = 1'b1;
          exp_bc_en[cc] = 1'b1;
          exp_bc[cc]    = BW'(N);
          if (st_abort[cc]) stop = 1'b1;
          cc++;
        end
        for (int j = 0; j < int'(C) && !stop && cc < k; j++) begin
          exp_o[cc][7] = 1'b1;
          exp_o[cc][2] = 1'b1;
          if (st_abort[cc]) stop = 1'b1;
          cc++;
        end
        if (!stop && cc < k) begin
          exp_o[cc][7] = 1'b1;
          exp_o[cc][1] = 1'b1;
          cc++;
        end
        c = cc;
      end else begin
        c++;
      end
    end
  endtask

  // One reset edge, then k cycles of stimulus; outputs recorded #1 after each edge.
  task automatic run_stim(input int k);
    reset = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < k; c++) begin
      obs_o[c]  = {busy, dest_ready, next_row, next_col, acc_clear, shift_en, done, err};
      obs_bc[c] = beat_cnt;
      start     = st_start[c];
      abort     = st_abort[c];
      src_valid = st_valid[c];
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; src_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b0; src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, dest_ready, next_row, next_col, acc_clear, shift_en, done, err, beat_cnt} !== '0) begin
        errors++;
        $display("FAIL reset cyc %0d outs=%b%b%b%b%b%b%b%b beat_cnt=%0d required all zero",
                 i, busy, dest_ready, next_row, next_col, acc_clear, shift_en, done, err, beat_cnt);
      end
    end
    start = 1'b0; src_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k = 40;
    clear_stim();
    st_start[0] = 1'b1;
    for (int i = 0; i < k; i++) st_valid[i] = 1'b1;
    build_model(k);
    run_stim(k);
    for (int c = 0; c < k; c++) begin
      checks++;
      if (obs_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL b2b cyc %0d outs got %b exp %b", c, obs_o[c], exp_o[c]);
      end
      if (exp_bc_en[c]) begin
        checks++;
        if (obs_bc[c] !== exp_bc[c]) begin
          errors++;
          $display("FAIL b2b beat_cnt cyc %0d got %0d exp %0d", c, obs_bc[c], exp_bc[c]);
        end
      end
    end
    checks++;
    if (obs_o[16][1] !== 1'b1 || obs_o[5][5] !== 1'b1 || obs_o[15][2] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timeline done16=%b next5=%b shift15=%b exp 1 1 1",
               obs_o[16][1], obs_o[5][5], obs_o[15][2]);
    end
  endtask

  task automatic test_stalled_load();
    int k = 40;
    clear_stim();
    st_start[0] = 1'b1;
    for (int i = 0; i < k; i++) st_valid[i] = (i != 2 && i != 3);
    build_model(k);
    run_stim(k);
    for (int c = 0; c < k; c++) begin
      checks++;
      if (obs_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL stall cyc %0d outs got %b exp %b", c, obs_o[c], exp_o[c]);
      end
      if (exp_bc_en[c]) begin
        checks++;
        if (obs_bc[c] !== exp_bc[c]) begin
          errors++;
          $display("FAIL stall beat_cnt cyc %0d got %0d exp %0d", c, obs_bc[c], exp_bc[c]);
        end
      end
    end
    checks++;
    if (obs_o[18][1] !== 1'b1 || obs_bc[3] !== BW'(1)) begin
      errors++;
      $display("FAIL stall_timeline done18=%b beat_cnt3=%0d exp 1 1", obs_o[18][1], obs_bc[3]);
    end
  endtask

  task automatic test_mid_compute_abort();
    int k = 40;
    clear_stim();
    st_start[0] = 1'b1;
    st_abort[8] = 1'b1;
    st_start[9] = 1'b1;
    for (int i = 0; i < k; i++) st_valid[i] = 1'b1;
    build_model(k);
    run_stim(k);
    for (int c = 0; c < k; c++) begin
      checks++;
      if (obs_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL abort cyc %0d outs got %b exp %b", c, obs_o[c], exp_o[c]);
      end
    end
    checks++;
    if (obs_o[9][7] !== 1'b0 || obs_o[9][2] !== 1'b0 || obs_o[25][1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_timeline busy9=%b shift9=%b done25=%b exp 0 0 1",
               obs_o[9][7], obs_o[9][2], obs_o[25][1]);
    end
  endtask

  task automatic test_collisions();
    int k = 30;
    int ndone = 0;
    clear_stim();
    st_start[0]  = 1'b1;
    st_start[10] = 1'b1;
    st_start[20] = 1'b1;
    st_abort[20] = 1'b1;
    for (int i = 0; i < k; i++) st_valid[i] = 1'b1;
    build_model(k);
    run_stim(k);
    for (int c = 0; c < k; c++) begin
      if (obs_o[c][1] === 1'b1) ndone++;
      checks++;
      if (obs_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL collide cyc %0d outs got %b exp %b", c, obs_o[c], exp_o[c]);
      end
    end
    checks++;
    if (ndone != 1 || obs_o[21][7] !== 1'b0) begin
      errors++;
      $display("FAIL collide_summary dones=%0d busy21=%b exp 1 0", ndone, obs_o[21][7]);
    end
  endtask

  task automatic test_random();
    int k = 120;
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int i = 0; i < k; i++) begin
        st_start[i] = ($urandom_range(0, 5) == 0);
        st_abort[i] = ($urandom_range(0, 39) == 0);
        st_valid[i] = ($urandom_range(0, 3) != 0);
      end
      build_model(k);
      run_stim(k);
      for (int c = 0; c < k; c++) begin
        checks++;
        if (obs_o[c] !== exp_o[c]) begin
          errors++;
          $display("FAIL random r%0d cyc %0d outs got %b exp %b", r, c, obs_o[c], exp_o[c]);
        end
        if (exp_bc_en[c]) begin
          checks++;
          if (obs_bc[c] !== exp_bc[c]) begin
            errors++;
            $display("FAIL random r%0d beat_cnt cyc %0d got %0d exp %0d", r, c, obs_bc[c], exp_bc[c]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int k = 80;
    int nerr = 0;
    int ndone = 0;
    clear_stim();
    st_start[0] = 1'b1;
    st_valid[1] = 1'b1;
    st_valid[2] = 1'b1;
    build_model(k);
    run_stim(k);
    for (int c = 0; c < k; c++) begin
      if (obs_o[c][0] === 1'b1) nerr++;
      if (obs_o[c][1] === 1'b1) ndone++;
    end
`ifdef LOAD_TIMEOUT_EN
    // Last beat accepted at cycle 2; 64 idle LOAD cycles later err is seen.
    checks++;
    if (obs_o[2 + TO + 1][0] !== 1'b1 || nerr != 1 || ndone != 0 || obs_o[2 + TO + 1][7] !== 1'b0) begin
      errors++;
      $display("FAIL timeout err@%0d=%b errs=%0d dones=%0d busy=%b exp 1 1 0 0",
               2 + TO + 1, obs_o[2 + TO + 1][0], nerr, ndone, obs_o[2 + TO + 1][7]);
    end
`else
    for (int c = 0; c < k; c++) begin
      checks++;
      if (obs_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL no_timeout cyc %0d outs got %b exp %b", c, obs_o[c], exp_o[c]);
      end
    end
    checks++;
    if (nerr != 0 || obs_o[k-1][7] !== 1'b1 || obs_o[k-1][6] !== 1'b1 || obs_bc[k-1] !== BW'(2)) begin
      errors++;
      $display("FAIL no_timeout_hold errs=%0d busy=%b ready=%b beat_cnt=%0d exp 0 1 1 2",
               nerr, obs_o[k-1][7], obs_o[k-1][6], obs_bc[k-1]);
    end
`endif
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_stalled_load();
    test_mid_compute_abort();
    test_collisions();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
